// File: rtl/axi_ethernet_0_reset_sequencer.sv
// Staged reset sequencer: filters MMCM lock, holds a minimum reset pulse, then releases
// NUM_CH reset outputs one by one (ch0 first), with per-channel soft reset while running.
module axi_ethernet_0_reset_sequencer #(
    parameter int                NUM_CH       = 4,
    parameter int                STAGE_CYCLES = 16,
    parameter int                LOCK_FILTER  = 8,
    parameter int                MIN_ASSERT   = 32,
    parameter logic [NUM_CH-1:0] ACT_LOW_MASK = 4'b0110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mmcm_locked_i,
    input  logic              soft_rst,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_released,
    output logic [1:0]        seq_state
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(MIN_ASSERT + 1);
    localparam int SW = $clog2(STAGE_CYCLES + 1);
    localparam int IW = $clog2(NUM_CH + 1);

    localparam logic [FW-1:0] FILT_FULL  = FW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MIN_ASSERT - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              lock_meta_r, lock_sync_r;
    logic [FW-1:0]     filt_cnt_r, filt_cnt_nxt_s;
    logic              lock_ok_s, abort_s;
    logic [HW-1:0]     hold_cnt_r, hold_cnt_nxt_s;
    logic [SW-1:0]     stage_cnt_r, stage_cnt_nxt_s;
    logic [IW-1:0]     idx_r, idx_nxt_s;
    logic [NUM_CH-1:0] act_r, act_nxt_s;
    logic [HW-1:0]     ch_cnt_r     [NUM_CH];
    logic [HW-1:0]     ch_cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] rst_out_r;
    logic              all_released_r;

    // Saturating run-length of consecutive synced-high lock samples; one low sample clears it
    always_comb begin
        filt_cnt_nxt_s = filt_cnt_r;
        if (!lock_sync_r) begin
            filt_cnt_nxt_s = '0;
        end else if (filt_cnt_r != FILT_FULL) begin
            filt_cnt_nxt_s = filt_cnt_r + FW'(1);
        end else begin
            filt_cnt_nxt_s = filt_cnt_r;
        end
    end

    assign lock_ok_s = (filt_cnt_r == FILT_FULL);
    assign abort_s   = !lock_ok_s || soft_rst;

    // Lock synchroniser and filter counter
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            filt_cnt_r  <= '0;
        end else begin
            lock_meta_r <= mmcm_locked_i;
            lock_sync_r <= lock_meta_r;
            filt_cnt_r  <= filt_cnt_nxt_s;
        end
    end

    // Sequencer next state, stage/hold counters and per-channel soft-reset timers
    always_comb begin
        state_nxt_s     = state_r;
        act_nxt_s       = act_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        stage_cnt_nxt_s = stage_cnt_r;
        idx_nxt_s       = idx_r;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_cnt_nxt_s[i] = ch_cnt_r[i];
        end

        case (state_r)
            ST_HOLD: begin
                act_nxt_s = '1;
                // Hold stays saturated while soft_rst is held, so the pulse can exceed MIN_ASSERT
                if ((hold_cnt_r == HOLD_LAST) && !soft_rst) begin
                    state_nxt_s = ST_WAIT;
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_nxt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            ST_WAIT: begin
                act_nxt_s = '1;
                if (abort_s) begin
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s     = ST_RELEASE;
                    stage_cnt_nxt_s = '0;
                    idx_nxt_s       = '0;
                end
            end
            ST_RELEASE: begin
                if (abort_s) begin
                    state_nxt_s    = ST_HOLD;
                    act_nxt_s      = '1;
                    hold_cnt_nxt_s = '0;
                end else if (stage_cnt_r == STAGE_LAST) begin
                    stage_cnt_nxt_s = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_r == IW'(i)) begin
                            act_nxt_s[i] = 1'b0;
                        end else begin
                            act_nxt_s[i] = act_r[i];
                        end
                    end
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        idx_nxt_s = idx_r + IW'(1);
                    end
                end else begin
                    stage_cnt_nxt_s = stage_cnt_r + SW'(1);
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_nxt_s    = ST_HOLD;
                    act_nxt_s      = '1;
                    hold_cnt_nxt_s = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        ch_cnt_nxt_s[i] = '0;
                    end
                end else begin
                    // A request (re)loads the timer; the channel drops one cycle after it reaches 0
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_rst_req[i]) begin
                            act_nxt_s[i]    = 1'b1;
                            ch_cnt_nxt_s[i] = HOLD_LAST;
                        end else if (act_r[i]) begin
                            if (ch_cnt_r[i] == '0) begin
                                act_nxt_s[i] = 1'b0;
                            end else begin
                                ch_cnt_nxt_s[i] = ch_cnt_r[i] - HW'(1);
                            end
                        end else begin
                            ch_cnt_nxt_s[i] = ch_cnt_r[i];
                        end
                    end
                end
            end
            default: begin
                state_nxt_s    = ST_HOLD;
                act_nxt_s      = '1;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // State, counters and outputs; outputs are built from next values so they track act with no lag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_HOLD;
            act_r          <= '1;
            hold_cnt_r     <= '0;
            stage_cnt_r    <= '0;
            idx_r          <= '0;
            rst_out_r      <= ~ACT_LOW_MASK;
            all_released_r <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_cnt_r[i] <= '0;
            end
        end else begin
            state_r        <= state_nxt_s;
            act_r          <= act_nxt_s;
            hold_cnt_r     <= hold_cnt_nxt_s;
            stage_cnt_r    <= stage_cnt_nxt_s;
            idx_r          <= idx_nxt_s;
            rst_out_r      <= act_nxt_s ^ ACT_LOW_MASK;
            all_released_r <= (state_nxt_s == ST_RUN) && (act_nxt_s == '0);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_cnt_r[i] <= ch_cnt_nxt_s[i];
            end
        end
    end

    assign rst_out      = rst_out_r;
    assign all_released = all_released_r;
    assign seq_state    = state_r;

endmodule

// File: tb/tb_axi_ethernet_0_reset_sequencer.sv
// Bench for the reset sequencer: directed scenarios plus random lock/soft/channel stimulus,
// checked every cycle against a timestamp-based reference model.
module tb_axi_ethernet_0_reset_sequencer;

    localparam int         NUM_CH       = 4;
    localparam int         STAGE_CYCLES = 16;
    localparam int         LOCK_FILTER  = 8;
    localparam int         MIN_ASSERT   = 32;
    localparam logic [3:0] MASK         = 4'b0110;
    localparam logic [3:0] ASSERTED     = ~MASK;
    localparam logic [3:0] RELEASED     = MASK;

    logic       clk = 1'b0;
    logic       rst;
    logic       mmcm_locked_i;
    logic       soft_rst;
    logic [3:0] ch_rst_req;
    logic [3:0] rst_out;
    logic       all_released;
    logic [1:0] seq_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Reference model: phase (0 hold, 1 wait, 2 release, 3 run) plus timestamps
    int cyc = 0;
    int m_phase, m_hold, rel_start;
    int run0, run1, run2;
    int ch_until [NUM_CH];

    int n, k, h, cnt_a, cnt_b;

    axi_ethernet_0_reset_sequencer #(
        .NUM_CH       (NUM_CH),
        .STAGE_CYCLES (STAGE_CYCLES),
        .LOCK_FILTER  (LOCK_FILTER),
        .MIN_ASSERT   (MIN_ASSERT),
        .ACT_LOW_MASK (MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmcm_locked_i (mmcm_locked_i),
        .soft_rst      (soft_rst),
        .ch_rst_req    (ch_rst_req),
        .rst_out       (rst_out),
        .all_released  (all_released),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic enter_hold();
        m_phase = 0;
        m_hold  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        bit ok_pre, abort;
        cyc++;
        if (rst) begin
            enter_hold();
            run0 = 0; run1 = 0; run2 = 0;
            for (int i = 0; i < NUM_CH; i++) ch_until[i] = 0;
        end else begin
            // lock_ok: the LOCK_FILTER raw samples taken 2+ edges ago were all high
            ok_pre = (run2 >= LOCK_FILTER);
            abort  = !ok_pre || soft_rst;
            case (m_phase)
                0: if (m_hold >= MIN_ASSERT - 1 && !soft_rst) m_phase = 1; else m_hold++;
                1: if (abort) enter_hold(); else begin m_phase = 2; rel_start = cyc; end
                2: begin
                    if (abort) enter_hold();
                    else if (cyc - rel_start >= NUM_CH * STAGE_CYCLES) begin
                        m_phase = 3;
                        for (int i = 0; i < NUM_CH; i++) ch_until[i] = 0;
                    end
                end
                default: begin
                    if (abort) enter_hold();
                    else for (int i = 0; i < NUM_CH; i++)
                        if (ch_rst_req[i]) ch_until[i] = cyc + MIN_ASSERT;
                end
            endcase
            run2 = run1;
            run1 = run0;
            run0 = mmcm_locked_i ? run0 + 1 : 0;
        end
    endtask

    function automatic logic [3:0] exp_active();
        logic [3:0] a;
        int released;
        a = 4'b1111;
        if (m_phase == 2) begin
            released = (cyc - rel_start) / STAGE_CYCLES;
            for (int i = 0; i < NUM_CH; i++) a[i] = (i >= released);
        end else if (m_phase == 3) begin
            for (int i = 0; i < NUM_CH; i++) a[i] = (cyc < ch_until[i]);
        end
        return a;
    endfunction

    task automatic step();
        logic [3:0] ea;
        @(posedge clk);
        model_edge();
        #1;
        ea = exp_active();
        check("rst_out", 32'(rst_out), 32'(ea ^ MASK));
        check("all_released", 32'(all_released), 32'((m_phase == 3) && (ea == 4'b0000)));
        check("seq_state", 32'(seq_state), 32'(m_phase));
    endtask

    task automatic wait_release(input string tag, input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            step();
            cycles++;
            if (all_released === 1'b1) break;
        end
        check({tag, "_within_bound"}, 32'(all_released === 1'b1), 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int bound);
        int c;
        c = 0;
        while (c < bound && seq_state !== s) begin
            step();
            c++;
        end
        check({tag, "_within_bound"}, 32'(seq_state), 32'(s));
    endtask

    initial begin
        rst           = 1'b1;
        mmcm_locked_i = 1'b1;
        soft_rst      = 1'b0;
        ch_rst_req    = 4'b0000;
        repeat (5) step();
        check("reset_rst_out", 32'(rst_out), 32'(ASSERTED));
        check("reset_state", 32'(seq_state), 32'd0);
        check("reset_all_released", 32'(all_released), 32'd0);

        // Power-up: WAIT at +32, RELEASE at +33, ch3 released at +33+64
        rst = 1'b0;
        wait_release("pwrup", 200, n);
        check("pwrup_release_cycle", 32'(n), 32'd97);
        check("pwrup_released_value", 32'(rst_out), 32'(RELEASED));
        repeat (10) step();

        // Channel soft reset on ch2, re-pulsed 20 cycles later
        ch_rst_req = 4'b0100;
        step();
        ch_rst_req = 4'b0000;
        h     = (rst_out === 4'b0010) ? 1 : 0;
        cnt_a = 0;
        for (int i = 1; i < 20; i++) begin
            step();
            if (rst_out === 4'b0010) h++;
            if (all_released === 1'b1) cnt_a++;
        end
        ch_rst_req = 4'b0100;
        step();
        ch_rst_req = 4'b0000;
        if (rst_out === 4'b0010) h++;
        for (int i = 0; i < 100; i++) begin
            step();
            if (rst_out === 4'b0010) begin
                h++;
                if (all_released === 1'b1) cnt_a++;
            end else break;
        end
        check("ch2_hold_len", 32'(h), 32'd52);
        check("ch2_all_released_low", 32'(cnt_a), 32'd0);
        check("ch2_after_release", 32'(rst_out), 32'(RELEASED));
        check("ch2_all_released_back", 32'(all_released), 32'd1);

        // One-cycle lock glitch in RUN
        mmcm_locked_i = 1'b0;
        step();
        mmcm_locked_i = 1'b1;
        k = 1;
        while (rst_out !== ASSERTED && k < 10) begin
            step();
            k++;
        end
        check("glitch_latency_le4", 32'((k <= 4) && (rst_out === ASSERTED)), 32'd1);
        h = 1;
        while (rst_out === ASSERTED && h < 200) begin
            step();
            if (rst_out === ASSERTED) h++;
        end
        check("glitch_hold_ge32", 32'(h >= MIN_ASSERT), 32'd1);
        wait_release("glitch", 300, n);

        // Soft reset held 100 cycles; release resumes once it drops
        soft_rst = 1'b1;
        cnt_a = 0;
        repeat (100) begin
            step();
            if (rst_out === ASSERTED) cnt_a++;
        end
        soft_rst = 1'b0;
        check("soft_held_100", 32'(cnt_a), 32'd100);
        check("soft_still_hold", 32'(seq_state), 32'd0);
        wait_release("soft", 200, n);
        check("soft_release_cycle", 32'(n), 32'd66);

        // Lock chatter: toggles every 5 cycles, filter never qualifies
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 200; i++) begin
            mmcm_locked_i = ((i / 5) % 2) == 1;
            step();
            if (seq_state === 2'd2) cnt_a++;
            if (seq_state === 2'd1) cnt_b++;
        end
        check("chatter_no_release", 32'(cnt_a), 32'd0);
        check("chatter_visits_wait", 32'(cnt_b > 0), 32'd1);
        mmcm_locked_i = 1'b1;
        wait_release("chatter", 300, n);

        // Priority: channel request together with soft reset
        ch_rst_req = 4'b1111;
        soft_rst   = 1'b1;
        step();
        ch_rst_req = 4'b0000;
        soft_rst   = 1'b0;
        check("prio_soft_vs_req", 32'(rst_out), 32'(ASSERTED));
        check("prio_soft_state", 32'(seq_state), 32'd0);

        // Priority: soft reset on the first stage terminal cycle
        wait_state("prio_rel1", 2'd2, 200);
        repeat (STAGE_CYCLES - 1) step();
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        check("prio_soft_terminal", 32'(rst_out), 32'(ASSERTED));
        check("prio_soft_terminal_state", 32'(seq_state), 32'd0);

        // Priority: lock-loss abort arriving on a stage terminal cycle
        wait_state("prio_rel2", 2'd2, 200);
        repeat (STAGE_CYCLES - 4) step();
        mmcm_locked_i = 1'b0;
        step();
        mmcm_locked_i = 1'b1;
        repeat (3) step();
        check("prio_lock_terminal", 32'(rst_out), 32'(ASSERTED));
        check("prio_lock_terminal_state", 32'(seq_state), 32'd0);
        wait_release("prio", 300, n);

        // Random mix of lock glitches, soft resets and channel requests
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r             = $urandom_range(0, 999);
            mmcm_locked_i = !(r < 4);
            soft_rst      = (r >= 4) && (r < 7);
            ch_rst_req    = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            step();
        end
        mmcm_locked_i = 1'b1;
        soft_rst      = 1'b0;
        ch_rst_req    = 4'b0000;
        wait_release("random_end", 300, n);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
